sp_ram_mb_wrap: RTL

//  Multi-bank, parametrised single-port data/instruction RAM wrapper with a req/gnt/rvalid handshake.

---
 rtl/sp_ram_mb_wrap_pkg.sv | 23 ++
 rtl/sp_ram_mb_wrap_bank.sv | 43 ++++
 rtl/sp_ram_mb_wrap.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_mb_wrap_pkg.sv
// Shared types and constants for the multi-bank single-port RAM wrapper.
// Optional build macro: SP_RAM_OUT_REG_EN (extra response register stage).
package sp_ram_mb_wrap_pkg;

    // Wrapper operating phase: zero-fill after reset, then normal service.
    typedef enum logic [0:0] {
        RAM_INIT = 1'b0,
        RAM_RUN  = 1'b1
    } ram_state_e;

    // Largest supported bank count.
    localparam int RAM_MAX_BANKS = 16;

    // Index width for a count of items, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        if (value > 1) begin
            return $clog2(value);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sp_ram_mb_wrap_bank.sv
// Behavioural byte-enable RAM bank with a one-cycle synchronous read.
// Stands in for the technology RAM macro on FPGA/ASIC targets.
module sp_ram_bank_model
    import sp_ram_mb_wrap_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          en,
    input  logic                          we,
    input  logic [DATA_WIDTH/8-1:0]       be,
    input  logic [clog2_min1(DEPTH)-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be[i]) begin
                    mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Synchronous read; the output word holds between reads.
    always_ff @(posedge clk) begin
        if (en && !we) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sp_ram_mb_wrap.sv
// Multi-bank single-port RAM wrapper with req/gnt/rvalid handshake.
// Word-interleaved banks, zero-fill after reset, bypass loopback and
// out-of-range detection. Build macro SP_RAM_OUT_REG_EN adds one more
// response register stage (latency 2 instead of 1).
module sp_ram_mb_wrap
    import sp_ram_mb_wrap_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic                      bypass_en_i,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      err_o,
    output logic                      init_done_o
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFFS_W    = $clog2(BYTES);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = clog2_min1(NUM_BANKS);
    localparam int DEPTH     = RAM_SIZE / (NUM_BANKS * BYTES);
    localparam int ROW_W     = clog2_min1(DEPTH);
    localparam int WORD_W    = ADDR_WIDTH - OFFS_W;

    localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(RAM_SIZE);
    localparam logic [ROW_W-1:0]    LAST_ROW  = ROW_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Address decode and range check
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] word_idx_s;
    logic [BANK_W-1:0] bank_sel_s;
    logic [ROW_W-1:0]  row_s;
    logic              oor_s;
    logic              addr_unused_s;

    assign word_idx_s    = addr_i[ADDR_WIDTH-1:OFFS_W];
    assign bank_sel_s    = BANK_W'(word_idx_s & WORD_W'(NUM_BANKS - 1));
    assign row_s         = ROW_W'(word_idx_s >> BANK_BITS);
    assign oor_s         = ({1'b0, addr_i} >= RAM_LIMIT);
    assign addr_unused_s = ^addr_i[OFFS_W-1:0];

    // ------------------------------------------------------------------
    // INIT / RUN state machine and zero-fill row counter
    // ------------------------------------------------------------------
    ram_state_e        state_r;
    ram_state_e        state_next_s;
    logic [ROW_W-1:0]  init_cnt_r;
    logic              init_done_r;

    // Next-state: leave INIT once the last row has been cleared.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RAM_INIT: begin
                if (init_cnt_r == LAST_ROW) begin
                    state_next_s = RAM_RUN;
                end else begin
                    state_next_s = RAM_INIT;
                end
            end
            RAM_RUN: begin
                state_next_s = RAM_RUN;
            end
            default: begin
                state_next_s = RAM_INIT;
            end
        endcase
    end

    // State, row counter and init-done flag registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= RAM_INIT;
            init_cnt_r  <= {ROW_W{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            init_done_r <= (state_next_s == RAM_RUN);
            if (state_r == RAM_INIT) begin
                init_cnt_r <= init_cnt_r + ROW_W'(1);
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    assign init_done_o = init_done_r;

    // ------------------------------------------------------------------
    // Request acceptance and bank drive
    // ------------------------------------------------------------------
    logic                  gnt_s;
    logic                  access_s;
    logic [NUM_BANKS-1:0]  bank_en_s;
    logic                  bank_we_s;
    logic [BYTES-1:0]      bank_be_s;
    logic [ROW_W-1:0]      bank_addr_s;
    logic [DATA_WIDTH-1:0] bank_wdata_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];

    assign gnt_s    = (state_r == RAM_RUN) && req_i;
    assign access_s = gnt_s && !oor_s && !bypass_en_i;
    assign gnt_o    = gnt_s;

    // Bank controls: broadcast zero-fill in INIT, one decoded bank in RUN.
    always_comb begin
        bank_en_s    = {NUM_BANKS{1'b0}};
        bank_we_s    = 1'b0;
        bank_be_s    = {BYTES{1'b0}};
        bank_addr_s  = {ROW_W{1'b0}};
        bank_wdata_s = {DATA_WIDTH{1'b0}};
        if (state_r == RAM_INIT) begin
            bank_en_s    = {NUM_BANKS{1'b1}};
            bank_we_s    = 1'b1;
            bank_be_s    = {BYTES{1'b1}};
            bank_addr_s  = init_cnt_r;
            bank_wdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            bank_we_s    = we_i;
            bank_be_s    = be_i;
            bank_addr_s  = row_s;
            bank_wdata_s = wdata_i;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_en_s[b] = access_s && (bank_sel_s == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sp_ram_bank_model #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en_s[b]),
            .we    (bank_we_s),
            .be    (bank_be_s),
            .addr  (bank_addr_s),
            .wdata (bank_wdata_s),
            .rdata (bank_rdata_s[b])
        );
    end

    // ------------------------------------------------------------------
    // First response stage: what kind of response is owed next cycle
    // ------------------------------------------------------------------
    logic                  s1_valid_r;
    logic                  s1_err_r;
    logic                  s1_byp_r;
    logic                  s1_rd_r;
    logic [BANK_W-1:0]     s1_bank_r;
    logic [DATA_WIDTH-1:0] s1_wdata_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] rsp_data_s;

    // Capture the accepted request's response class alongside the bank read.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s1_err_r   <= 1'b0;
            s1_byp_r   <= 1'b0;
            s1_rd_r    <= 1'b0;
            s1_bank_r  <= {BANK_W{1'b0}};
            s1_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_valid_r <= gnt_s;
            s1_err_r   <= gnt_s && oor_s && !bypass_en_i;
            s1_byp_r   <= gnt_s && bypass_en_i;
            s1_rd_r    <= gnt_s && !we_i && !oor_s && !bypass_en_i;
            s1_bank_r  <= bank_sel_s;
            s1_wdata_r <= wdata_i;
        end
    end

    // Response data select; writes and idle cycles keep the last value.
    always_comb begin
        rsp_data_s = hold_r;
        if (s1_err_r) begin
            rsp_data_s = {DATA_WIDTH{1'b0}};
        end else if (s1_byp_r) begin
            rsp_data_s = s1_wdata_r;
        end else if (s1_rd_r) begin
            rsp_data_s = bank_rdata_s[s1_bank_r];
        end else begin
            rsp_data_s = hold_r;
        end
    end

    // Remember the last presented data so rdata_o holds between responses.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            hold_r <= {DATA_WIDTH{1'b0}};
        end else begin
            hold_r <= rsp_data_s;
        end
    end

`ifdef SP_RAM_OUT_REG_EN
    // ------------------------------------------------------------------
    // Optional second stage: fully registered response outputs
    // ------------------------------------------------------------------
    logic                  out_valid_r;
    logic                  out_err_r;
    logic [DATA_WIDTH-1:0] out_data_r;

    // Register the selected response one more cycle; order is preserved.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            out_valid_r <= s1_valid_r;
            out_err_r   <= s1_err_r;
            out_data_r  <= rsp_data_s;
        end
    end

    assign rvalid_o = out_valid_r;
    assign err_o    = out_err_r;
    assign rdata_o  = out_data_r;
`else
    assign rvalid_o = s1_valid_r;
    assign err_o    = s1_err_r;
    assign rdata_o  = rsp_data_s;
`endif

endmodule
